ysyx_imm_decode_stage: RTL and testbench
========================================

Name: ysyx_imm_decode_stage

Overview:
Registered immediate-generation stage between IFU and IDU for the multi-cycle/pipelined NPC. Decodes the format of every RV32I/RV64I base opcode, including S, B, CSR-zimm and shift-amount formats. Produces an XLEN-wide immediate plus a format tag and an illegal flag. Decoupled by a valid/ready register slice with a one-entry skid buffer, so full throughput is kept under backpressure; supports synchronous flush.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64; immediates sign/zero-extended to XLEN.
RV64, (XLEN==64), enables OP-IMM-32/OP-32 opcodes and 6-bit shamt.

Ports:
clk  input  1  clock.
rst_n  input  1  asynchronous active-low reset.
flush  input  1  synchronous kill of all held entries.
in_valid  input  1  upstream instruction valid.
in_ready  output  1  stage can accept.
in_inst  input  32  instruction word.
in_pc  input  XLEN  instruction PC.
out_valid  output  1  decoded entry valid.
out_ready  input  1  downstream accepts.
out_inst  output  32  registered instruction.
out_pc  output  XLEN  registered PC.
out_imm  output  XLEN  extended immediate.
out_fmt  output  3  0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z, 7 SHAMT.
out_illegal  output  1  unsupported encoding.

Behaviour:
- Decode (combinational, on the input side):
  - LUI/AUIPC give U: inst[31:12],12'b0, sign-extended to XLEN.
  - LOAD/JALR/OP-IMM (non-shift) give I: sext(inst[31:20]).
  - STORE gives S: sext({inst[31:25],inst[11:7]}).
  - BRANCH gives B: sext({inst[31],inst[7],inst[30:25],inst[11:8],1'b0}).
  - JAL gives J: sext({inst[31],inst[19:12],inst[20],inst[30:21],1'b0}).
  - OP-IMM funct3 001/101 gives SHAMT: zext(inst[25:20]) if RV64, else zext(inst[24:20]). inst[25]=1 with XLEN=32 sets illegal.
  - OP-IMM-32 (0011011, RV64 only): I, or SHAMT zext(inst[24:20]).
  - SYSTEM funct3[2]=1 gives Z: zext(inst[19:15]). Other SYSTEM, OP, OP-32 (RV64), FENCE give NONE, imm 0.
  - Any other opcode, inst[1:0]!=2'b11, or RV64-only opcodes with XLEN=32: NONE, imm 0, illegal=1.
- Pipeline:
  - Registers: main (drives out_*) and skid. Latency is one cycle from in-handshake to out_valid.
  - in_ready = !skid_valid, taken directly from the flop.
  - Main loads when !out_valid or out_ready. It loads from skid if skid_valid, else from the input when in_valid&&in_ready.
  - When an input is accepted while main holds and !out_ready, the input goes to skid.
  - Order is strictly FIFO. One transfer per cycle sustained with out_ready=1.
- Flush: next cycle out_valid=0 and skid_valid=0. An input handshake in the flush cycle is dropped. Flush has priority over every load.
- Reset (async, any time, including mid-transfer):
  - out_valid=0, skid_valid=0, in_ready=1.
  - out_inst=0, out_pc=0, out_imm=0, out_fmt=0, out_illegal=0.
- Payload outputs hold stable while out_valid&&!out_ready.

Test Plan:
- Immediate formats (XLEN=32), one cycle latency each:
  - LUI 0x123450B7: imm 0x12345000, fmt 4.
  - JAL 0xFFDFF06F: imm 0xFFFFFFFC, fmt 5.
  - BEQ 0xFE000CE3: imm 0xFFFFFFF8, fmt 3.
  - SW 0xFE512E23: imm 0xFFFFFFFC, fmt 2.
- CSRRWI 0x300FD073 -> imm 0x1F, fmt 6.
- SLLI 0x03F09093:
  - XLEN=64: imm 63, fmt 7, illegal 0.
  - XLEN=32: illegal 1.
- Backpressure:
  - Stimulus: stream A,B,C back-to-back; out_ready=0 for 3 cycles after A arrives, then 1.
  - Response: A held stable; B sits in skid; in_ready=0 while C is offered; C is not lost. Output order is A,B,C, then one per cycle.
- Flush with main and skid both full, plus a concurrent in_valid: next cycle out_valid=0, in_ready=1, and the concurrent input never appears.
- Reset edges:
  - Assert rst_n=0 mid-stall: all outputs take their reset values immediately (async).
  - Release: in_ready=1, and the first new input appears after one cycle.
- Opcode 0x0000007F or inst[1:0]=00: fmt 0, imm 0, illegal 1.

Source files
------------

// File: rtl/ysyx_imm_decode_stage.sv
// ysyx_imm_decode_stage: RV32I/RV64I immediate decode behind a valid/ready skid slice (in_* upstream, out_* registered decode, flush, async rst_n)
module ysyx_imm_decode_stage #(
  parameter int XLEN = 32,
  parameter bit RV64 = (XLEN == 64)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_inst,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_illegal
);
  localparam int W = 32 + 2 * XLEN + 4;
  logic [6:0] op;
  logic [2:0] f3, fmt;
  logic is_sh, ill, acc, ld, skid_valid;
  logic [XLEN-1:0] i_imm, s_imm, b_imm, u_imm, j_imm, z_imm, sh_imm, sh32_imm, imm;
  logic [W-1:0] d, main_q, skid_q;
  assign op = in_inst[6:0];
  assign f3 = in_inst[14:12];
  assign is_sh = f3[1:0] == 2'b01;
  assign i_imm = XLEN'({{52{in_inst[31]}}, in_inst[31:20]});
  assign s_imm = XLEN'({{52{in_inst[31]}}, in_inst[31:25], in_inst[11:7]});
  assign b_imm = XLEN'({{52{in_inst[31]}}, in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0});
  assign u_imm = XLEN'({{32{in_inst[31]}}, in_inst[31:12], 12'b0});
  assign j_imm = XLEN'({{44{in_inst[31]}}, in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0});
  assign z_imm = XLEN'({59'b0, in_inst[19:15]});
  assign sh_imm = XLEN'({58'b0, RV64 & in_inst[25], in_inst[24:20]});
  assign sh32_imm = XLEN'({59'b0, in_inst[24:20]});
  always_comb begin
    fmt = 3'd0;
    imm = '0;
    ill = 1'b0;
    if (in_inst[1:0] != 2'b11) ill = 1'b1;
    else case (op)
      7'b0110111, 7'b0010111: begin fmt = 3'd4; imm = u_imm; end
      7'b0000011, 7'b1100111: begin fmt = 3'd1; imm = i_imm; end
      7'b0010011: begin
        fmt = is_sh ? 3'd7 : 3'd1;
        imm = is_sh ? sh_imm : i_imm;
        ill = is_sh && !RV64 && in_inst[25];
      end
      7'b0011011: begin
        fmt = !RV64 ? 3'd0 : is_sh ? 3'd7 : 3'd1;
        imm = !RV64 ? '0 : is_sh ? sh32_imm : i_imm;
        ill = !RV64;
      end
      7'b0100011: begin fmt = 3'd2; imm = s_imm; end
      7'b1100011: begin fmt = 3'd3; imm = b_imm; end
      7'b1101111: begin fmt = 3'd5; imm = j_imm; end
      7'b1110011: begin fmt = f3[2] ? 3'd6 : 3'd0; imm = f3[2] ? z_imm : '0; end
      7'b0110011, 7'b0001111: ;
      7'b0111011: ill = !RV64;
      default: ill = 1'b1;
    endcase
  end
  assign d = {in_inst, in_pc, imm, fmt, ill};
  assign {out_inst, out_pc, out_imm, out_fmt, out_illegal} = main_q;
  assign in_ready = !skid_valid;
  assign acc = in_valid && in_ready;
  assign ld = !out_valid || out_ready;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_q <= '0;
      skid_q <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (ld) begin
      out_valid <= skid_valid || acc;
      skid_valid <= 1'b0;
      if (skid_valid) main_q <= skid_q;
      else if (acc) main_q <= d;
    end else if (acc) begin
      skid_q <= d;
      skid_valid <= 1'b1;
    end
  end
endmodule

// File: tb/tb_ysyx_imm_decode_stage.sv
// tb_ysyx_imm_decode_stage: directed checks of decode formats, skid backpressure, flush and async reset
module tb_ysyx_imm_decode_stage;
  logic clk = 0, rst_n = 0, flush = 0, in_valid = 0, out_ready = 1;
  logic [31:0] in_inst = '0;
  logic [63:0] pc = '0;
  logic r32, v32, il32, r64, v64, il64;
  logic [31:0] oi32, op32, im32, oi64;
  logic [63:0] op64, im64;
  logic [2:0] f32, f64;
  int n_cmp = 0, n_err = 0;
  localparam int N = 14;
  logic [31:0] t_inst [N] = '{32'h123450B7, 32'hFFDFF06F, 32'hFE000CE3, 32'hFE512E23, 32'h300FD073, 32'h03F09093,
    32'hFFF00093, 32'h0000007F, 32'h00000000, 32'h0010009B, 32'h4030D093, 32'h00000073, 32'h00208033, 32'h80000017};
  logic [31:0] e_imm32 [N] = '{32'h12345000, 32'hFFFFFFFC, 32'hFFFFFFF8, 32'hFFFFFFFC, 32'h1F, 32'h1F,
    32'hFFFFFFFF, 0, 0, 0, 32'h3, 0, 0, 32'h80000000};
  logic [2:0] e_fmt32 [N] = '{4, 5, 3, 2, 6, 7, 1, 0, 0, 0, 7, 0, 0, 4};
  logic e_ill32 [N] = '{0, 0, 0, 0, 0, 1, 0, 1, 1, 1, 0, 0, 0, 0};
  logic [63:0] e_imm64 [N] = '{64'h12345000, 64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFFFFFFFFF8, 64'hFFFFFFFFFFFFFFFC, 64'h1F, 64'h3F,
    64'hFFFFFFFFFFFFFFFF, 0, 0, 64'h1, 64'h3, 0, 0, 64'hFFFFFFFF80000000};
  logic [2:0] e_fmt64 [N] = '{4, 5, 3, 2, 6, 7, 1, 0, 0, 1, 7, 0, 0, 4};
  logic e_ill64 [N] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0};
  always #5 clk = ~clk;
  ysyx_imm_decode_stage #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(r32), .in_inst(in_inst),
    .in_pc(pc[31:0]), .out_valid(v32), .out_ready(out_ready), .out_inst(oi32), .out_pc(op32),
    .out_imm(im32), .out_fmt(f32), .out_illegal(il32));
  ysyx_imm_decode_stage #(.XLEN(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(r64), .in_inst(in_inst),
    .in_pc(pc), .out_valid(v64), .out_ready(out_ready), .out_inst(oi64), .out_pc(op64),
    .out_imm(im64), .out_fmt(f64), .out_illegal(il64));
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [31:0] i, input logic [63:0] p);
    in_valid = 1;
    in_inst = i;
    pc = p;
    tick();
    in_valid = 0;
  endtask
  initial begin
    #2;
    chk("rst out_valid", v32, 0);
    chk("rst in_ready", r32, 1);
    chk("rst inst", oi32, 0);
    chk("rst imm", im32, 0);
    chk("rst fmt", f32, 0);
    chk("rst illegal", il32, 0);
    @(negedge clk) rst_n = 1;
    tick();
    for (int k = 0; k < N; k++) begin
      send(t_inst[k], 64'h1000 + 64'(k * 4));
      chk($sformatf("v32[%0d]", k), v32, 1);
      chk($sformatf("inst32[%0d]", k), oi32, t_inst[k]);
      chk($sformatf("pc32[%0d]", k), op32, 32'h1000 + 32'(k * 4));
      chk($sformatf("imm32[%0d]", k), im32, e_imm32[k]);
      chk($sformatf("fmt32[%0d]", k), f32, e_fmt32[k]);
      chk($sformatf("ill32[%0d]", k), il32, e_ill32[k]);
      chk($sformatf("imm64[%0d]", k), im64, e_imm64[k]);
      chk($sformatf("fmt64[%0d]", k), f64, e_fmt64[k]);
      chk($sformatf("ill64[%0d]", k), il64, e_ill64[k]);
    end
    tick();
    chk("drain idle", v32, 0);
    out_ready = 0;
    in_valid = 1; in_inst = 32'h00100093; pc = 64'h200;
    tick();
    chk("bp A valid", v32, 1);
    chk("bp A inst", oi32, 32'h00100093);
    chk("bp ready A", r32, 1);
    in_inst = 32'h00200093; pc = 64'h204;
    tick();
    chk("bp A hold1", oi32, 32'h00100093);
    chk("bp skid full", r32, 0);
    in_inst = 32'h00300093; pc = 64'h208;
    tick();
    chk("bp A hold2", oi32, 32'h00100093);
    chk("bp A pc", op32, 32'h200);
    chk("bp C blocked", r32, 0);
    tick();
    chk("bp A hold3", oi32, 32'h00100093);
    chk("bp A imm", im32, 1);
    out_ready = 1;
    tick();
    chk("bp B inst", oi32, 32'h00200093);
    chk("bp B imm", im32, 2);
    chk("bp ready after B", r32, 1);
    tick();
    chk("bp C inst", oi32, 32'h00300093);
    chk("bp C pc", op32, 32'h208);
    in_inst = 32'h00400093; pc = 64'h20C;
    tick();
    chk("bp D inst", oi32, 32'h00400093);
    chk("bp D valid", v32, 1);
    in_valid = 0;
    tick();
    chk("bp idle", v32, 0);
    out_ready = 0;
    in_valid = 1; in_inst = 32'h00500093; pc = 64'h300;
    tick();
    in_inst = 32'h00600093; pc = 64'h304;
    tick();
    chk("fl full", r32, 0);
    flush = 1; in_inst = 32'h00700093; pc = 64'h308;
    tick();
    flush = 0; in_valid = 0;
    chk("fl valid", v32, 0);
    chk("fl ready", r32, 1);
    out_ready = 1;
    tick();
    chk("fl no late", v32, 0);
    flush = 1; in_valid = 1; in_inst = 32'h00900093;
    tick();
    flush = 0; in_valid = 0;
    chk("fl drop hs", v32, 0);
    tick();
    chk("fl drop hs2", v32, 0);
    out_ready = 0;
    in_valid = 1; in_inst = 32'h123450B7; pc = 64'h400;
    tick();
    in_inst = 32'h00800093;
    tick();
    in_valid = 0;
    chk("rs stalled", r32, 0);
    #2 rst_n = 0;
    #1;
    chk("rs valid", v32, 0);
    chk("rs ready", r32, 1);
    chk("rs inst", oi32, 0);
    chk("rs pc", op32, 0);
    chk("rs imm", im32, 0);
    chk("rs fmt", f32, 0);
    chk("rs ill", il32, 0);
    chk("rs valid64", v64, 0);
    chk("rs imm64", im64, 0);
    @(negedge clk) rst_n = 1;
    out_ready = 1; in_valid = 1; in_inst = 32'hFFDFF06F; pc = 64'h500;
    #1;
    chk("rel ready", r32, 1);
    chk("rel valid0", v32, 0);
    @(posedge clk);
    #1;
    in_valid = 0;
    chk("rel valid", v32, 1);
    chk("rel inst", oi32, 32'hFFDFF06F);
    chk("rel imm", im32, 32'hFFFFFFFC);
    tick();
    chk("rel idle", v32, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
